// File: rtl/vscale_hasti_arbiter.sv
// vscale_hasti_arbiter
// Shares one AHB-Lite (HASTI) master port between NUM_PORTS core-side
// request ports. The address phase is combinational from the winning
// requester. The data phase follows one registered stage later, so address
// and data phases of consecutive transfers overlap. Arbitration is
// round-robin: the search starts just after the last accepted port.
//
// Optional build macro: HASTI_ARB_LOCK_EN
//   When it is defined, the core_mem_lock input is added. A port whose
//   accepted transfer is locked keeps the bus until it issues an unlocked
//   transfer or stops requesting.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   core_mem_en/wen/size/addr     per-port request (address phase)
//   core_mem_wdata_delayed        per-port write data (data phase)
//   core_mem_lock                 per-port lock request (lock builds only)
//   core_mem_rdata/wait/badmem_e  per-port read data, stall, bus error
//   haddr..hwdata                 AHB-Lite master outputs
//   hrdata, hready, hresp         AHB-Lite slave responses
module vscale_hasti_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_PORTS-1:0]            core_mem_en,
  input  logic [NUM_PORTS-1:0]            core_mem_wen,
  input  logic [3*NUM_PORTS-1:0]          core_mem_size,
  input  logic [ADDR_WIDTH*NUM_PORTS-1:0] core_mem_addr,
  input  logic [DATA_WIDTH*NUM_PORTS-1:0] core_mem_wdata_delayed,
`ifdef HASTI_ARB_LOCK_EN
  input  logic [NUM_PORTS-1:0]            core_mem_lock,
`endif
  output logic [DATA_WIDTH*NUM_PORTS-1:0] core_mem_rdata,
  output logic [NUM_PORTS-1:0]            core_mem_wait,
  output logic [NUM_PORTS-1:0]            core_badmem_e,
  output logic [ADDR_WIDTH-1:0]           haddr,
  output logic                            hwrite,
  output logic [2:0]                      hsize,
  output logic [2:0]                      hburst,
  output logic                            hmastlock,
  output logic [3:0]                      hprot,
  output logic [1:0]                      htrans,
  output logic [DATA_WIDTH-1:0]           hwdata,
  input  logic [DATA_WIDTH-1:0]           hrdata,
  input  logic                            hready,
  input  logic                            hresp
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_NONSEQ = 2'b10
  } htrans_e;

  logic [ADDR_WIDTH-1:0] w_addr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_PORTS];
  logic [2:0]            w_size  [NUM_PORTS];

  logic          w_rrGrantValid;
  logic [PW-1:0] w_rrGrantIdx;
  logic          w_grantValid;
  logic [PW-1:0] w_grantIdx;

  logic          r_dphaseValid;
  logic [PW-1:0] r_dphasePort;
  logic          r_dphaseWrite;
  logic [PW-1:0] r_rrPtr;

  // Port index reached by stepping 'offset' places past 'base', wrapping at
  // NUM_PORTS. The port count need not be a power of two. Because offset
  // never exceeds NUM_PORTS, one conditional subtract is enough.
  function automatic logic [PW-1:0] portAfter(input logic [PW-1:0] base,
                                               input int offset);
    int k;
    k = int'(base) + offset;
    if (k >= NUM_PORTS) k = k - NUM_PORTS;
    return PW'(k);
  endfunction

  // Split the flat per-port buses into arrays so that the granted port and
  // the data-phase port can be selected by plain indexing.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_addr[i]  = core_mem_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_wdata[i] = core_mem_wdata_delayed[i*DATA_WIDTH +: DATA_WIDTH];
      w_size[i]  = core_mem_size[i*3 +: 3];
    end
  end

  // Round-robin search starting one place after the last accepted port.
  // The loop walks from the farthest candidate to the nearest one, so the
  // nearest requesting port is the last one written and therefore wins.
  // With a single port this reduces to grant = core_mem_en[0].
  always_comb begin
    w_rrGrantValid = 1'b0;
    w_rrGrantIdx   = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      if (core_mem_en[portAfter(r_rrPtr, i)]) begin
        w_rrGrantValid = 1'b1;
        w_rrGrantIdx   = portAfter(r_rrPtr, i);
      end
    end
  end

`ifdef HASTI_ARB_LOCK_EN
  logic          r_lockHold;
  logic [PW-1:0] r_lockPort;

  // A held lock pins the grant to the owning port. If that port is idle,
  // the bus stays reserved and htrans shows IDLE. Reset also masks the
  // grant, so nothing is driven onto the bus while reset_n is low.
  always_comb begin
    if (r_lockHold) begin
      w_grantValid = reset_n & core_mem_en[r_lockPort];
      w_grantIdx   = r_lockPort;
    end else begin
      w_grantValid = reset_n & w_rrGrantValid;
      w_grantIdx   = w_rrGrantIdx;
    end
  end

  // Every accepted transfer refreshes the lock from its own lock bit. The
  // lock is therefore set by a locked accept and cleared by an unlocked
  // accept from the owner. An owner that stops requesting while the bus
  // is ready also gives up the lock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lockHold <= 1'b0;
      r_lockPort <= '0;
    end else if (hready) begin
      if (w_grantValid) begin
        r_lockHold <= core_mem_lock[w_grantIdx];
        r_lockPort <= w_grantIdx;
      end else if (r_lockHold) begin
        r_lockHold <= 1'b0;
      end
    end
  end

  assign hmastlock = w_grantValid & core_mem_lock[w_grantIdx];
`else
  // Without lock support the grant is pure round-robin. It is masked
  // during reset so the bus stays idle while reset_n is low.
  always_comb begin
    w_grantValid = reset_n & w_rrGrantValid;
    w_grantIdx   = w_rrGrantIdx;
  end

  assign hmastlock = 1'b0;
`endif

  // Pipeline register between the address phase and the data phase. An
  // accept needs hready, and a low hready freezes everything so that the
  // stalled data phase keeps pointing at its owner. After reset the
  // round-robin pointer sits on the last port, so port 0 is searched first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dphaseValid <= 1'b0;
      r_dphasePort  <= '0;
      r_dphaseWrite <= 1'b0;
      r_rrPtr       <= LAST_PORT;
    end else if (hready) begin
      if (w_grantValid) begin
        r_dphaseValid <= 1'b1;
        r_dphasePort  <= w_grantIdx;
        r_dphaseWrite <= core_mem_wen[w_grantIdx];
        r_rrPtr       <= w_grantIdx;
      end else begin
        r_dphaseValid <= 1'b0;
      end
    end
  end

  // Address-phase outputs come straight from the granted requester. When
  // there is no grant they are zero so the bus shows a clean IDLE.
  always_comb begin
    htrans = TRANS_IDLE;
    haddr  = '0;
    hwrite = 1'b0;
    hsize  = 3'b000;
    if (w_grantValid) begin
      htrans = TRANS_NONSEQ;
      haddr  = w_addr[w_grantIdx];
      hwrite = core_mem_wen[w_grantIdx];
      hsize  = w_size[w_grantIdx];
    end
  end

  assign hburst = 3'b000;
  assign hprot  = 4'b0011;

  // Write data is taken live from the data-phase owner. The core holds it
  // steady while hready is low.
  always_comb begin
    hwdata = '0;
    if (r_dphaseValid && r_dphaseWrite) hwdata = w_wdata[r_dphasePort];
  end

  // Per-port returns. Read data and the bus error go only to the data-phase
  // owner. The error flag follows hresp directly, so it stays high for both
  // cycles of a two-cycle ERROR response. A low hready stalls every port.
  // A requesting port that lost arbitration also waits.
  always_comb begin
    core_mem_rdata = '0;
    core_mem_wait  = '0;
    core_badmem_e  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_dphaseValid && r_dphasePort == PW'(i) && !r_dphaseWrite)
        core_mem_rdata[i*DATA_WIDTH +: DATA_WIDTH] = hrdata;
      core_badmem_e[i] = r_dphaseValid & (r_dphasePort == PW'(i)) & hresp;
      core_mem_wait[i] = ~hready |
                         (core_mem_en[i] & ~(w_grantValid & (w_grantIdx == PW'(i))));
    end
  end

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// tb_vscale_hasti_arbiter
// Directed bench for the two-port default configuration. Each task drives
// one scenario and compares the outputs against hand-computed values.
// Inputs are driven on the falling clock edge. Outputs are sampled 1 ns
// later, well before the next rising edge.
module tb_vscale_hasti_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  core_mem_en;
  logic [1:0]  core_mem_wen;
  logic [5:0]  core_mem_size;
  logic [63:0] core_mem_addr;
  logic [63:0] core_mem_wdata_delayed;
`ifdef HASTI_ARB_LOCK_EN
  logic [1:0]  core_mem_lock;
`endif
  logic [63:0] core_mem_rdata;
  logic [1:0]  core_mem_wait;
  logic [1:0]  core_badmem_e;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hmastlock;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  int nChecks = 0;
  int nErrors = 0;

  vscale_hasti_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .core_mem_en(core_mem_en),
    .core_mem_wen(core_mem_wen),
    .core_mem_size(core_mem_size),
    .core_mem_addr(core_mem_addr),
    .core_mem_wdata_delayed(core_mem_wdata_delayed),
`ifdef HASTI_ARB_LOCK_EN
    .core_mem_lock(core_mem_lock),
`endif
    .core_mem_rdata(core_mem_rdata),
    .core_mem_wait(core_mem_wait),
    .core_badmem_e(core_badmem_e),
    .haddr(haddr),
    .hwrite(hwrite),
    .hsize(hsize),
    .hburst(hburst),
    .hmastlock(hmastlock),
    .hprot(hprot),
    .htrans(htrans),
    .hwdata(hwdata),
    .hrdata(hrdata),
    .hready(hready),
    .hresp(hresp)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sets the request fields of one port. The size is always WORD.
  task automatic applyStimulus(input int p, input logic en, input logic wen,
                               input logic [31:0] addr);
    core_mem_en[p]             = en;
    core_mem_wen[p]            = wen;
    core_mem_size[p*3 +: 3]    = 3'b010;
    core_mem_addr[p*32 +: 32]  = addr;
  endtask

  // Holds reset for one cycle with all requests dropped
  task automatic doReset();
    @(negedge clk);
    reset_n     = 1'b0;
    core_mem_en = '0;
    @(negedge clk);
    reset_n     = 1'b1;
  endtask

  // Checks the idle values driven in reset, including with requests pending
  task automatic test_reset();
    @(negedge clk);
    #1;
    nChecks++; if (htrans !== 2'b00) begin nErrors++; $display("[TB] FAIL reset_htrans: got %h want 0", htrans); end
    nChecks++; if (haddr !== 32'h0) begin nErrors++; $display("[TB] FAIL reset_haddr: got %h want 0", haddr); end
    nChecks++; if (hwrite !== 1'b0 || hsize !== 3'b000) begin nErrors++; $display("[TB] FAIL reset_hwrite_hsize: got %b/%h want 0/0", hwrite, hsize); end
    nChecks++; if (core_mem_rdata !== 64'h0) begin nErrors++; $display("[TB] FAIL reset_rdata: got %h want 0", core_mem_rdata); end
    nChecks++; if (core_badmem_e !== 2'b00 || hmastlock !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_badmem_lock: got %b/%b want 00/0", core_badmem_e, hmastlock); end
    nChecks++; if (hburst !== 3'b000 || hprot !== 4'b0011) begin nErrors++; $display("[TB] FAIL reset_consts: got %h/%h want 0/3", hburst, hprot); end
    applyStimulus(0, 1'b1, 1'b0, 32'h44);
    #1;
    nChecks++; if (htrans !== 2'b00) begin nErrors++; $display("[TB] FAIL reset_req_htrans: got %h want 0", htrans); end
    core_mem_en = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Single read from port 0 with a one-cycle data phase
  task automatic test_single_read();
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 32'h100);
    #1;
    nChecks++; if (htrans !== 2'b10) begin nErrors++; $display("[TB] FAIL read_htrans: got %h want 2", htrans); end
    nChecks++; if (haddr !== 32'h100 || hwrite !== 1'b0 || hsize !== 3'b010) begin nErrors++; $display("[TB] FAIL read_addr: got %h/%b/%h want 100/0/2", haddr, hwrite, hsize); end
    nChecks++; if (core_mem_wait !== 2'b00) begin nErrors++; $display("[TB] FAIL read_wait: got %b want 00", core_mem_wait); end
    @(negedge clk);
    core_mem_en = '0;
    hrdata      = 32'hDEADBEEF;
    #1;
    nChecks++; if (core_mem_rdata !== {32'h0, 32'hDEADBEEF}) begin nErrors++; $display("[TB] FAIL read_rdata: got %h want 00000000deadbeef", core_mem_rdata); end
    nChecks++; if (htrans !== 2'b00) begin nErrors++; $display("[TB] FAIL read_idle_after: got %h want 0", htrans); end
    @(negedge clk);
    #1;
    nChecks++; if (core_mem_rdata !== 64'h0) begin nErrors++; $display("[TB] FAIL read_rdata_clear: got %h want 0", core_mem_rdata); end
    hrdata = 32'h0;
  endtask

  // Two ports requesting from reset must alternate 0,1,0,1. Each read data
  // beat must go to the port accepted in the previous cycle.
  task automatic test_contention();
    int expPort [4] = '{0, 1, 0, 1};
    logic [31:0] expAddr;
    logic [1:0]  expWait;
    logic [63:0] expRdata;
    doReset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      applyStimulus(0, 1'b1, 1'b0, 32'h10);
      applyStimulus(1, 1'b1, 1'b0, 32'h20);
      hrdata  = 32'hA0 + 32'(k);
      expAddr = (expPort[k] == 0) ? 32'h10 : 32'h20;
      expWait = (expPort[k] == 0) ? 2'b10 : 2'b01;
      expRdata = 64'h0;
      if (k > 0) expRdata[expPort[k-1]*32 +: 32] = 32'hA0 + 32'(k);
      #1;
      nChecks++; if (haddr !== expAddr) begin nErrors++; $display("[TB] FAIL rr_grant[%0d]: got %h want %h", k, haddr, expAddr); end
      nChecks++; if (core_mem_wait !== expWait) begin nErrors++; $display("[TB] FAIL rr_wait[%0d]: got %b want %b", k, core_mem_wait, expWait); end
      nChecks++; if (core_mem_rdata !== expRdata) begin nErrors++; $display("[TB] FAIL rr_rdata[%0d]: got %h want %h", k, core_mem_rdata, expRdata); end
    end
    @(negedge clk);
    core_mem_en = '0;
    hrdata      = 32'h0;
  endtask

  // Port 1 write whose data phase is stretched by two wait states. Port 0
  // requests during the stall and must not be accepted until hready returns.
  task automatic test_write_stall();
    @(negedge clk);
    applyStimulus(1, 1'b1, 1'b1, 32'h200);
    #1;
    nChecks++; if (haddr !== 32'h200 || hwrite !== 1'b1 || core_mem_wait !== 2'b00) begin nErrors++; $display("[TB] FAIL wr_addr: got %h/%b/%b want 200/1/00", haddr, hwrite, core_mem_wait); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      core_mem_en[1] = 1'b0;
      core_mem_wdata_delayed[63:32] = 32'h12345678;
      hready = 1'b0;
      applyStimulus(0, 1'b1, 1'b0, 32'h300);
      #1;
      nChecks++; if (hwdata !== 32'h12345678) begin nErrors++; $display("[TB] FAIL wr_stall_hwdata[%0d]: got %h want 12345678", k, hwdata); end
      nChecks++; if (core_mem_wait !== 2'b11) begin nErrors++; $display("[TB] FAIL wr_stall_wait[%0d]: got %b want 11", k, core_mem_wait); end
      nChecks++; if (haddr !== 32'h300 || htrans !== 2'b10) begin nErrors++; $display("[TB] FAIL wr_stall_addr[%0d]: got %h/%h want 300/2", k, haddr, htrans); end
    end
    @(negedge clk);
    hready = 1'b1;
    #1;
    nChecks++; if (hwdata !== 32'h12345678) begin nErrors++; $display("[TB] FAIL wr_release_hwdata: got %h want 12345678", hwdata); end
    nChecks++; if (core_mem_wait !== 2'b00) begin nErrors++; $display("[TB] FAIL wr_release_wait: got %b want 00", core_mem_wait); end
    @(negedge clk);
    core_mem_en = '0;
    core_mem_wdata_delayed = '0;
    hrdata = 32'hCAFEF00D;
    #1;
    nChecks++; if (hwdata !== 32'h0) begin nErrors++; $display("[TB] FAIL wr_after_hwdata: got %h want 0", hwdata); end
    nChecks++; if (core_mem_rdata !== {32'h0, 32'hCAFEF00D}) begin nErrors++; $display("[TB] FAIL wr_after_rdata: got %h want 00000000cafef00d", core_mem_rdata); end
    @(negedge clk);
    hrdata = 32'h0;
  endtask

  // Two-cycle ERROR response on a port 0 read. A port 1 request during the
  // second error cycle is presented normally.
  task automatic test_error();
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 32'h400);
    @(negedge clk);
    core_mem_en = '0;
    hready = 1'b0;
    hresp  = 1'b1;
    #1;
    nChecks++; if (core_badmem_e !== 2'b01) begin nErrors++; $display("[TB] FAIL err_cycle1: got %b want 01", core_badmem_e); end
    @(negedge clk);
    hready = 1'b1;
    applyStimulus(1, 1'b1, 1'b0, 32'h500);
    #1;
    nChecks++; if (core_badmem_e !== 2'b01) begin nErrors++; $display("[TB] FAIL err_cycle2: got %b want 01", core_badmem_e); end
    nChecks++; if (htrans !== 2'b10 || haddr !== 32'h500) begin nErrors++; $display("[TB] FAIL err_next_addr: got %h/%h want 2/500", htrans, haddr); end
    @(negedge clk);
    core_mem_en = '0;
    hresp = 1'b0;
    #1;
    nChecks++; if (core_badmem_e !== 2'b00) begin nErrors++; $display("[TB] FAIL err_clear: got %b want 00", core_badmem_e); end
    @(negedge clk);
  endtask

  // Asynchronous reset during a port 1 read data phase. The data must vanish
  // at once, and port 0 must win first after the release.
  task automatic test_reset_mid();
    @(negedge clk);
    applyStimulus(1, 1'b1, 1'b0, 32'h600);
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 32'h700);
    applyStimulus(1, 1'b1, 1'b0, 32'h800);
    hrdata = 32'h55AA55AA;
    #1;
    nChecks++; if (core_mem_rdata !== {32'h55AA55AA, 32'h0}) begin nErrors++; $display("[TB] FAIL rst_mid_pre_rdata: got %h want 55aa55aa00000000", core_mem_rdata); end
    reset_n = 1'b0;
    #1;
    nChecks++; if (core_mem_rdata !== 64'h0) begin nErrors++; $display("[TB] FAIL rst_mid_rdata: got %h want 0", core_mem_rdata); end
    nChecks++; if (htrans !== 2'b00 || haddr !== 32'h0) begin nErrors++; $display("[TB] FAIL rst_mid_idle: got %h/%h want 0/0", htrans, haddr); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    nChecks++; if (haddr !== 32'h700 || htrans !== 2'b10) begin nErrors++; $display("[TB] FAIL rst_mid_first_grant: got %h/%h want 700/2", haddr, htrans); end
    nChecks++; if (core_mem_wait !== 2'b10 || core_mem_rdata !== 64'h0) begin nErrors++; $display("[TB] FAIL rst_mid_after: got %b/%h want 10/0", core_mem_wait, core_mem_rdata); end
    @(negedge clk);
    core_mem_en = '0;
    hrdata = 32'h0;
    @(negedge clk);
  endtask

`ifdef HASTI_ARB_LOCK_EN
  // Port 0 makes two locked accesses and then one unlocked access while
  // port 1 keeps requesting. Port 1 must only win after the unlocked one.
  task automatic test_lock();
    logic [1:0] lockSeq [3] = '{2'b01, 2'b01, 2'b00};
    doReset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      applyStimulus(0, 1'b1, 1'b0, 32'h900);
      applyStimulus(1, 1'b1, 1'b0, 32'hA00);
      core_mem_lock = lockSeq[k];
      #1;
      nChecks++; if (haddr !== 32'h900 || core_mem_wait !== 2'b10) begin nErrors++; $display("[TB] FAIL lock_hold[%0d]: got %h/%b want 900/10", k, haddr, core_mem_wait); end
      nChecks++; if (hmastlock !== lockSeq[k][0]) begin nErrors++; $display("[TB] FAIL lock_hmastlock[%0d]: got %b want %b", k, hmastlock, lockSeq[k][0]); end
    end
    @(negedge clk);
    core_mem_lock = '0;
    #1;
    nChecks++; if (haddr !== 32'hA00 || core_mem_wait !== 2'b01) begin nErrors++; $display("[TB] FAIL lock_release: got %h/%b want a00/01", haddr, core_mem_wait); end
    @(negedge clk);
    core_mem_en = '0;
  endtask
`endif

  // Scenario sequence followed by the summary line
  initial begin
    reset_n = 1'b0;
    core_mem_en = '0;
    core_mem_wen = '0;
    core_mem_size = '0;
    core_mem_addr = '0;
    core_mem_wdata_delayed = '0;
`ifdef HASTI_ARB_LOCK_EN
    core_mem_lock = '0;
`endif
    hrdata = '0;
    hready = 1'b1;
    hresp  = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_write_stall();
    test_error();
    test_reset_mid();
`ifdef HASTI_ARB_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
